// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand feeder.
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } feeder_state_e;

  // FEED lasts 2*DIM-1 steps; DRAIN covers the DIM-1 PE hops to the far corner.
  function automatic int unsigned feed_len(int unsigned dim);
    return 2 * dim - 1;
  endfunction

  function automatic int unsigned drain_len(int unsigned dim);
    return dim - 1;
  endfunction

  // LSB position of element [row][col] in a row-major flat matrix bus.
  function automatic int unsigned elem_lsb(int unsigned row, int unsigned col,
                                           int unsigned dim, int unsigned width);
    return (row * dim + col) * width;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Start handshake, matrix operands and skewed lane outputs of the systolic feeder.
interface systolic_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM        = 4
);

  logic                           start_i;
  logic [DIM*DIM*DATA_WIDTH-1:0]  a_i;
  logic [DIM*DIM*DATA_WIDTH-1:0]  b_i;
  logic                           ready_o;
  logic                           clr_o;
  logic [DIM*DATA_WIDTH-1:0]      west_o;
  logic [DIM*DATA_WIDTH-1:0]      north_o;
  logic                           valid_o;
  logic                           done_o;

  modport master (
    output start_i, a_i, b_i,
    input  ready_o, clr_o, west_o, north_o, valid_o, done_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output ready_o, clr_o, west_o, north_o, valid_o, done_o
  );

endinterface

// File: rtl/systolic_skew_lane.sv
// One skewed lane: emits element (step - LANE) of its vector while inside the window, else 0.
module systolic_skew_lane #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM        = 4,
  parameter int unsigned LANE       = 0,
  parameter int unsigned CNT_BITS   = 4
) (
  input  logic [CNT_BITS-1:0]       step_i,
  input  logic [DIM*DATA_WIDTH-1:0] vec_i,
  output logic [DATA_WIDTH-1:0]     elem_o
);

  always_comb begin
    elem_o = '0;
    for (int unsigned k = 0; k < DIM; k++) begin
      if (step_i == CNT_BITS'(LANE + k)) begin
        elem_o = vec_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer feeding diagonally skewed A/B streams into a DIM x DIM systolic array.
// Define FEEDER_TRANSPOSE_EN to take b_i column-major instead of row-major.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM        = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  systolic_feeder_if.slave   bus
);

  localparam int unsigned CNT_BITS  = $clog2(3 * DIM);
  localparam int unsigned FEED_LEN  = feed_len(DIM);
  localparam int unsigned DRAIN_LEN = drain_len(DIM);
  localparam int unsigned MAT_W     = DIM * DIM * DATA_WIDTH;
  localparam int unsigned LANE_W    = DIM * DATA_WIDTH;
  localparam logic [CNT_BITS-1:0] FeedLast  = CNT_BITS'(FEED_LEN - 1);
  localparam logic [CNT_BITS-1:0] DrainLast = CNT_BITS'(DRAIN_LEN - 1);

  feeder_state_e       state_q, state_d;
  logic [CNT_BITS-1:0] step_q, step_d;
  logic [MAT_W-1:0]    a_q, a_d, b_q, b_d;
  logic                ready_q, ready_d, clr_q, clr_d;
  logic                valid_q, valid_d, done_q, done_d;
  logic [LANE_W-1:0]   west_q, west_d, north_q, north_d;
  logic [LANE_W-1:0]   west_lane, north_lane;
  logic                accept;

  assign accept = (state_q == StIdle) && bus.start_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ready_q <= 1'b1;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      west_q  <= '0;
      north_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ready_q <= ready_d;
      clr_q   <= clr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      west_q  <= west_d;
      north_q <= north_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d = StFeed;
          step_d  = '0;
          a_d     = bus.a_i;
          b_d     = bus.b_i;
        end
      end
      StFeed: begin
        if (step_q >= FeedLast) begin
          state_d = StDrain;
          step_d  = '0;
        end else begin
          step_d = step_q + CNT_BITS'(1);
        end
      end
      StDrain: begin
        if (step_q >= DrainLast) begin
          state_d = StDone;
          step_d  = '0;
        end else begin
          step_d = step_q + CNT_BITS'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        step_d  = '0;
      end
      default: begin
        state_d = StIdle;
        step_d  = '0;
      end
    endcase
  end

  // Outputs are precomputed from the next state so every port comes straight from a flop.
  always_comb begin
    ready_d = (state_d == StIdle);
    clr_d   = accept;
    valid_d = (state_d == StFeed);
    done_d  = (state_d == StDone);
    west_d  = valid_d ? west_lane  : '0;
    north_d = valid_d ? north_lane : '0;
  end

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    logic [LANE_W-1:0] north_vec;

    for (genvar k = 0; k < DIM; k++) begin : g_elem
`ifdef FEEDER_TRANSPOSE_EN
      assign north_vec[k*DATA_WIDTH +: DATA_WIDTH] =
          b_d[elem_lsb(r, k, DIM, DATA_WIDTH) +: DATA_WIDTH];
`else
      assign north_vec[k*DATA_WIDTH +: DATA_WIDTH] =
          b_d[elem_lsb(k, r, DIM, DATA_WIDTH) +: DATA_WIDTH];
`endif
    end

    systolic_skew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DIM        (DIM),
      .LANE       (r),
      .CNT_BITS   (CNT_BITS)
    ) u_west (
      .step_i (step_d),
      .vec_i  (a_d[elem_lsb(r, 0, DIM, DATA_WIDTH) +: LANE_W]),
      .elem_o (west_lane[r*DATA_WIDTH +: DATA_WIDTH])
    );

    systolic_skew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DIM        (DIM),
      .LANE       (r),
      .CNT_BITS   (CNT_BITS)
    ) u_north (
      .step_i (step_d),
      .vec_i  (north_vec),
      .elem_o (north_lane[r*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.ready_o = ready_q;
  assign bus.clr_o   = clr_q;
  assign bus.valid_o = valid_q;
  assign bus.done_o  = done_q;
  assign bus.west_o  = west_q;
  assign bus.north_o = north_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder at DIM=4 and DIM=2 with hand-computed skewed streams.
module tb_systolic_feeder;

  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [31:0] west;
    logic [31:0] north;
    logic        clr;
  } feed_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mon_en;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  feed_t       exp4_q[$];
  feed_t       exp2_q[$];
  int unsigned done4_q[$];
  int unsigned done2_q[$];
  feed_t       e4, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_feeder_if #(.DATA_WIDTH(DW), .DIM(4)) bus4 ();
  systolic_feeder_if #(.DATA_WIDTH(DW), .DIM(2)) bus2 ();

  systolic_feeder #(.DATA_WIDTH(DW), .DIM(4)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4)
  );

  systolic_feeder #(.DATA_WIDTH(DW), .DIM(2)) u_dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int unsigned ap(int unsigned r, int unsigned k, int unsigned dim);
    return (r * dim + k) * DW;
  endfunction

  // Position of B[k][c] in b_i for the current build.
  function automatic int unsigned bp(int unsigned k, int unsigned c, int unsigned dim);
`ifdef FEEDER_TRANSPOSE_EN
    return (c * dim + k) * DW;
`else
    return (k * dim + c) * DW;
`endif
  endfunction

  task automatic push4(input logic [31:0] w, input logic [31:0] n, input logic c);
    exp4_q.push_back('{west: w, north: n, clr: c});
  endtask

  task automatic push2(input logic [15:0] w, input logic [15:0] n, input logic c);
    exp2_q.push_back('{west: {16'h0, w}, north: {16'h0, n}, clr: c});
  endtask

  // Diagonal pattern: A[0][0]=4 A[1][1]=2 A[2][2]=7, B[0][0]=3 B[1][1]=3 B[2][2]=1.
  task automatic set_t1();
    bus4.a_i = '0;
    bus4.b_i = '0;
    bus4.a_i[ap(0, 0, 4) +: DW] = 8'd4;
    bus4.a_i[ap(1, 1, 4) +: DW] = 8'd2;
    bus4.a_i[ap(2, 2, 4) +: DW] = 8'd7;
    bus4.b_i[bp(0, 0, 4) +: DW] = 8'd3;
    bus4.b_i[bp(1, 1, 4) +: DW] = 8'd3;
    bus4.b_i[bp(2, 2, 4) +: DW] = 8'd1;
  endtask

  task automatic push_t1(input int unsigned e);
    push4(32'h0000_0004, 32'h0000_0003, 1'b1);
    push4(32'h0, 32'h0, 1'b0);
    push4(32'h0000_0200, 32'h0000_0300, 1'b0);
    push4(32'h0, 32'h0, 1'b0);
    push4(32'h0007_0000, 32'h0001_0000, 1'b0);
    push4(32'h0, 32'h0, 1'b0);
    push4(32'h0, 32'h0, 1'b0);
    done4_q.push_back(e + 10);
  endtask

  // Corner pattern: A[3][0]=9, B[0][3]=6 -> both appear on lane 3 at t=3.
  task automatic set_t2();
    bus4.a_i = '0;
    bus4.b_i = '0;
    bus4.a_i[ap(3, 0, 4) +: DW] = 8'd9;
    bus4.b_i[bp(0, 3, 4) +: DW] = 8'd6;
  endtask

  task automatic push_t2(input int unsigned e);
    push4(32'h0, 32'h0, 1'b1);
    push4(32'h0, 32'h0, 1'b0);
    push4(32'h0, 32'h0, 1'b0);
    push4(32'h0900_0000, 32'h0600_0000, 1'b0);
    push4(32'h0, 32'h0, 1'b0);
    push4(32'h0, 32'h0, 1'b0);
    push4(32'h0, 32'h0, 1'b0);
    done4_q.push_back(e + 10);
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp4_q.size() == 0 && done4_q.size() == 0 &&
          exp2_q.size() == 0 && done2_q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start4(output int unsigned e);
    @(negedge clk);
    bus4.start_i = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    bus4.start_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus4.valid_o) begin
        if (exp4_q.size() == 0) begin
          fail_now("dut4 unexpected valid");
        end else begin
          e4 = exp4_q.pop_front();
          check("dut4 west", {32'h0, bus4.west_o}, {32'h0, e4.west});
          check("dut4 north", {32'h0, bus4.north_o}, {32'h0, e4.north});
          check("dut4 clr", {63'h0, bus4.clr_o}, {63'h0, e4.clr});
        end
      end else begin
        check("dut4 lanes zero outside feed", {bus4.west_o, bus4.north_o}, 64'h0);
        check("dut4 clr outside feed", {63'h0, bus4.clr_o}, 64'h0);
      end
      if (bus4.done_o) begin
        if (done4_q.size() == 0) fail_now("dut4 unexpected done");
        else check("dut4 done cycle", 64'(cyc), 64'(done4_q.pop_front()));
      end

      if (bus2.valid_o) begin
        if (exp2_q.size() == 0) begin
          fail_now("dut2 unexpected valid");
        end else begin
          e2 = exp2_q.pop_front();
          check("dut2 west", {48'h0, bus2.west_o}, {32'h0, e2.west});
          check("dut2 north", {48'h0, bus2.north_o}, {32'h0, e2.north});
          check("dut2 clr", {63'h0, bus2.clr_o}, {63'h0, e2.clr});
        end
      end else begin
        check("dut2 lanes zero outside feed", {32'h0, bus2.west_o, bus2.north_o}, 64'h0);
      end
      if (bus2.done_o) begin
        if (done2_q.size() == 0) fail_now("dut2 unexpected done");
        else check("dut2 done cycle", 64'(cyc), 64'(done2_q.pop_front()));
      end
    end
  end

  initial begin
    int unsigned e;
    rst          = 1'b0;
    mon_en       = 1'b0;
    bus4.start_i = 1'b0;
    bus4.a_i     = '0;
    bus4.b_i     = '0;
    bus2.start_i = 1'b0;
    bus2.a_i     = '0;
    bus2.b_i     = '0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset ready4", {63'h0, bus4.ready_o}, 64'h1);
    check("reset outs4", {28'h0, bus4.clr_o, bus4.valid_o, bus4.done_o, 1'b0,
                          bus4.west_o}, 64'h0);
    check("reset north4", {32'h0, bus4.north_o}, 64'h0);
    check("reset ready2", {63'h0, bus2.ready_o}, 64'h1);
    check("reset outs2", {29'h0, bus2.clr_o, bus2.valid_o, bus2.done_o,
                          bus2.west_o, bus2.north_o}, 64'h0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // DIM=4 diagonal pattern.
    set_t1();
    start4(e);
    push_t1(e);
    check("dut4 ready low in feed", {63'h0, bus4.ready_o}, 64'h0);
    wait_drain();
    check("dut4 ready after op", {63'h0, bus4.ready_o}, 64'h1);

    // DIM=2 full matrices.
    bus2.a_i = '0;
    bus2.b_i = '0;
    bus2.a_i[ap(0, 0, 2) +: DW] = 8'd1;
    bus2.a_i[ap(0, 1, 2) +: DW] = 8'd2;
    bus2.a_i[ap(1, 0, 2) +: DW] = 8'd3;
    bus2.a_i[ap(1, 1, 2) +: DW] = 8'd4;
    bus2.b_i[bp(0, 0, 2) +: DW] = 8'd5;
    bus2.b_i[bp(0, 1, 2) +: DW] = 8'd6;
    bus2.b_i[bp(1, 0, 2) +: DW] = 8'd7;
    bus2.b_i[bp(1, 1, 2) +: DW] = 8'd8;
    @(negedge clk);
    bus2.start_i = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    bus2.start_i = 1'b0;
    push2(16'h0001, 16'h0005, 1'b1);
    push2(16'h0302, 16'h0607, 1'b0);
    push2(16'h0400, 16'h0800, 1'b0);
    done2_q.push_back(e + 4);
    wait_drain();

    // start_i held high: second latch only in the cycle after done_o.
    set_t1();
    @(negedge clk);
    bus4.start_i = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    push_t1(e);
    bus4.a_i = '1;
    bus4.b_i = '1;
    wait_cyc(e + 11);
    check("dut4 ready cycle after done", {63'h0, bus4.ready_o}, 64'h1);
    set_t2();
    @(posedge clk);
    #1;
    push_t2(cyc);
    check("dut4 held start accepted", 64'(cyc), 64'(e + 12));
    check("dut4 ready low after relatch", {63'h0, bus4.ready_o}, 64'h0);
    bus4.start_i = 1'b0;
    wait_drain();

    // Reset during FEED step 3 aborts with no done_o.
    set_t1();
    start4(e);
    push_t1(e);
    wait_cyc(e + 3);
    #1 rst = 1'b1;
    #1;
    check("abort ready", {63'h0, bus4.ready_o}, 64'h1);
    check("abort outs", {29'h0, bus4.clr_o, bus4.valid_o, bus4.done_o, 32'h0}, 64'h0);
    check("abort lanes", {bus4.west_o, bus4.north_o}, 64'h0);
    exp4_q.delete();
    done4_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    set_t1();
    start4(e);
    push_t1(e);
    wait_drain();

    check("dut4 feed queue drained", 64'(exp4_q.size()), 64'h0);
    check("dut4 done queue drained", 64'(done4_q.size()), 64'h0);
    check("dut2 feed queue drained", 64'(exp2_q.size()), 64'h0);
    check("dut2 done queue drained", 64'(done2_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Parametrised operand sequencer for the DIM x DIM systolic multiplier array.
- Latches two square matrices A and B on a start handshake.
- Generates the diagonally skewed west and north streams, with zeros outside each lane's window.
- Holds off while the array drains, then pulses done.
- Replaces hand-written skewed stimulus; sits directly in front of the array's west_i/north_i inputs.

Parameters:
DATA_WIDTH, 8, bits per matrix element
DIM, 4, array dimension (rows = cols = lanes), >= 2
CNT_BITS, $clog2(3*DIM), width of internal step counter (localparam)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  start request; accepted only when ready_o=1
a_i  input  DIM*DIM*DATA_WIDTH  matrix A, element A[r][k] at bits [(r*DIM+k)*DATA_WIDTH +: DATA_WIDTH]
b_i  input  DIM*DIM*DATA_WIDTH  matrix B, element B[k][c] at bits [(k*DIM+c)*DATA_WIDTH +: DATA_WIDTH]
ready_o  output  1  idle, can accept start
clr_o  output  1  one-cycle accumulator clear pulse to array
west_o  output  DIM*DATA_WIDTH  west lane r at [r*DATA_WIDTH +: DATA_WIDTH], lane 0 in the LSBs
north_o  output  DIM*DATA_WIDTH  north lane c, same packing
valid_o  output  1  high while west_o/north_o carry feed data
done_o  output  1  one-cycle pulse: products final in array

Behaviour:
- Reset (async, any state): state=IDLE, step=0; outputs ready_o=1, clr_o=0, west_o=0, north_o=0, valid_o=0, done_o=0; latched matrices cleared to 0.
- All outputs are registered.
- Reset mid-operation aborts immediately. No done_o is issued.
- IDLE:
  - ready_o=1.
  - start_i=1 latches a_i/b_i, pulses clr_o for the next cycle, and moves to FEED with step=0.
  - start_i while not IDLE is ignored. It is neither queued nor re-latched.
- FEED: steps t = 0 .. 2*DIM-2 (2*DIM-1 cycles); valid_o=1; ready_o=0.
  - West lane r = A[r][t-r] when 0 <= t-r < DIM, otherwise 0.
  - North lane c = B[t-c][c] when 0 <= t-c < DIM, otherwise 0.
  - The first FEED cycle coincides with clr_o=1.
  - At t=2*DIM-2, go to DRAIN.
- DRAIN: DIM-1 cycles; west_o=north_o=0; valid_o=0. Covers one-cycle-per-PE hop latency to PE(DIM-1,DIM-1). Then go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE with ready_o=1 in the next cycle.
- Latency: start accepted at edge n -> first feed data at n+1 -> done_o at n+1+(2*DIM-1)+(DIM-1) = n+3*DIM-1.
- Back-to-back: minimum start spacing is 3*DIM cycles. The cycle after done_o may accept a new start.
- No arithmetic is performed. Element values pass through unmodified, with no sign interpretation.
- step counter saturates at its final value per state and never wraps.

Optional Feature:
FEEDER_TRANSPOSE_EN
- Defined: b_i is taken column-major, i.e. bits [(c*DIM+k)*DATA_WIDTH +: DATA_WIDTH] hold B[k][c]. North lane c streams that column contiguously. Timing is unchanged.
- Undefined: row-major b_i as in Ports.
- a_i is unaffected either way.

Decomposition:
- Package systolic_pkg:
  - state encoding typedef (IDLE, FEED, DRAIN, DONE);
  - localparams FEED_LEN=2*DIM-1 and DRAIN_LEN=DIM-1;
  - an element-index helper function for flat-bus slicing.
- One natural sub-module: systolic_skew_lane. It is instantiated per lane with a lane-index parameter and a DIM-element vector input, and emits its element or zero for step t. It is used for both west and north.

Test Plan:
- Reset: assert rst_i mid-cycle with no clock edge -> all outputs 0 and ready_o=1 immediately.
- DIM=4, A[0][0]=4, A[1][1]=2, A[2][2]=7, B row0 col0=3, B[1][1]=3, B[2][2]=1, all others 0, start -> next cycle: clr_o=1, west_o={0,0,0,4}, north_o={0,0,0,3}.
  - Following steps: t=2 {0,0,2,0}/{0,0,3,0}; t=4 {0,7,0,0}/{0,1,0,0}.
  - All other steps zero. valid_o high for exactly 7 cycles.
- DIM=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> west t0..t2 = {0,1},{3,2},{4,0}; north = {0,5},{6,7},{8,0}.
  - done_o exactly 5 cycles after the start edge, lasting 1 cycle.
- start_i held high continuously -> second latch only in the cycle after done_o; intervening starts are ignored and a_i changes during FEED have no effect on outputs.
- rst_i pulse during FEED step 3 -> outputs zero at once, no done_o; a subsequent start yields a complete correct sequence.
- With FEEDER_TRANSPOSE_EN, DIM=2, b_i column-major for B=[[5,6],[7,8]] -> north stream identical to the row-major DIM=2 case.
